instr_sequencer: RTL and testbench
==================================

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 The block SHALL have parameter PROG_START, default 0, giving the first instruction address fetched after start.
REQ-002 The block SHALL have parameter IMEM_AW, default 8, giving the instruction address width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1 bit, the run request, sampled only in IDLE or HALTED.
REQ-006 The block SHALL have port abort, input, 1 bit, a synchronous cancel of the running program.
REQ-007 The block SHALL have port imem_rd_en, output, 1 bit, the instruction read strobe.
REQ-008 The block SHALL have port imem_addr, output, IMEM_AW bits, the instruction address (equal to pc).
REQ-009 The block SHALL have port imem_rdata, input, 16 bits, the instruction word, valid one cycle after imem_rd_en.
REQ-010 The block SHALL have ports alu_op (3 bits), alu_a (8 bits) and alu_b (8 bits), all outputs, the external ALU operands (registered).
REQ-011 The block SHALL have ports alu_result (8 bits) and alu_zero (1 bit), both inputs, the combinational ALU response.
REQ-012 The block SHALL have ports busy, done and zero_flag, all outputs, 1 bit each.
REQ-013 The block SHALL have port retired, output, 16 bits, the count of retired instructions.
REQ-014 The block SHALL have a debug read port: dbg_addr input, 4 bits; dbg_data output, 8 bits, a combinational register-file read.

Function
REQ-015 The instruction format SHALL be: [15:13] op, [12] ignored, [11:8] rd, [7:4] rs1, [3:0] rs2; for LDI, [7:0] holds imm8.
REQ-016 Op codes 000-101 SHALL be ALU ops, passed unchanged on alu_op (ADD, SUB, AND, OR, XOR, NOR); op 110 SHALL be LDI; op 111 SHALL be HALT.
REQ-017 The register file SHALL hold 16 x 8-bit registers; r0 SHALL always read 0x00, and writes to it are discarded.
REQ-018 The FSM SHALL have the states IDLE, FETCH, DECODE, EXEC, WB and HALTED.
REQ-019 IDLE/HALTED with start=1 SHALL go to FETCH, load pc with PROG_START, clear retired and clear zero_flag.
REQ-020 FETCH SHALL assert imem_rd_en for exactly one cycle, then go to DECODE.
REQ-021 DECODE SHALL latch imem_rdata into the IR, then act by op:
  - HALT: go to HALTED.
  - LDI: go to WB.
  - ALU op: latch the rs1/rs2 register values into alu_a/alu_b, set alu_op, go to EXEC.
REQ-022 EXEC SHALL capture alu_result and alu_zero, then go to WB.
REQ-023 WB SHALL write rd (imm8 for LDI, the captured result for ALU ops), then:
  - pc = pc + 1, wrapping modulo 2^IMEM_AW;
  - retired += 1, saturating at 0xFFFF;
  - go to FETCH.
REQ-024 zero_flag SHALL update only in the WB of an ALU op; LDI and HALT SHALL leave it unchanged.
REQ-025 Latency SHALL be 4 cycles per ALU instruction, 3 per LDI, and 2 from HALT fetch to HALTED.
REQ-026 done SHALL pulse high for exactly one cycle on entry to HALTED.
REQ-027 busy SHALL be high in FETCH, DECODE, EXEC and WB, and low in IDLE and HALTED.
REQ-028 start while busy SHALL be ignored.
REQ-029 abort=1 while busy SHALL force IDLE on the next edge, with no register write, pc update, retired update or done in that cycle.
REQ-030 If abort and start are both high in IDLE/HALTED, abort SHALL win and the block SHALL stay in or enter IDLE.
REQ-031 Register contents SHALL persist across start, abort and HALTED; only reset clears them.

Reset
REQ-032 While reset_n=0, the block SHALL hold state IDLE and drive:
  - pc = PROG_START, IR = 0;
  - all registers = 0x00;
  - alu_op/alu_a/alu_b = 0;
  - imem_rd_en, busy, done and zero_flag = 0;
  - retired = 0.
REQ-033 Assertion of reset_n mid-instruction SHALL take effect immediately, without waiting for a clock edge, and SHALL discard any pending write.

Verification
REQ-034 Reset: assert reset_n=0 mid-EXEC -> immediately all outputs are 0, dbg_data reads 0x00 for every register, and FSM is IDLE.
REQ-035 Program LDI r1,0x05; LDI r2,0x03; SUB r3,r1,r2; HALT -> r3=0x02, zero_flag=0, retired=3, done pulses once 12 clocks after the start-sampling edge.
REQ-036 LDI r1,0xFF; LDI r2,0x01; ADD r4,r1,r2; HALT -> r4=0x00, zero_flag=1 (8-bit wrap); then LDI r5,0x00 leaves zero_flag=1.
REQ-037 LDI r0,0xAA; OR r6,r0,r0 -> dbg r0=0x00, r6=0x00, zero_flag=1.
REQ-038 abort raised in EXEC of ADD r7,... -> IDLE next clock, r7 unchanged, busy=0, done never asserted, retired unchanged.
REQ-039 PROG_START=255, LDI r1,0x11 at address 255, HALT at address 0 -> pc wraps to 0, HALTED reached, r1=0x11.

Source files
------------

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle fetch/decode/exec/writeback sequencer with a 16x8 register file
// and an external combinational ALU.
module instr_sequencer #(
  parameter int PROG_START = 0,
  parameter int IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               abort,
  output logic               imem_rd_en,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [15:0]        imem_rdata,
  output logic [2:0]         alu_op,
  output logic [7:0]         alu_a,
  output logic [7:0]         alu_b,
  input  logic [7:0]         alu_result,
  input  logic               alu_zero,
  output logic               busy,
  output logic               done,
  output logic               zero_flag,
  output logic [15:0]        retired,
  input  logic [3:0]         dbg_addr,
  output logic [7:0]         dbg_data
);
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALTED} state_t;
  state_t r_state, w_next;
  logic [IMEM_AW-1:0] r_pc;
  logic [15:0] r_ir, r_retired;
  logic [7:0] r_rf [16];
  logic [7:0] r_res, r_alu_a, r_alu_b;
  logic [2:0] r_alu_op;
  logic r_res_zero, r_zero, r_done;
  logic [2:0] w_op;
  logic w_idle, w_start, w_ldi, w_unused;
  // Decode decisions use the memory word directly; it is only valid during DECODE.
  assign w_op = imem_rdata[15:13];
  assign w_idle = r_state == S_IDLE || r_state == S_HALTED;
  assign w_start = w_idle && start && !abort;
  assign w_ldi = r_ir[15:13] == OP_LDI;
  assign w_unused = r_ir[12];
  assign imem_rd_en = r_state == S_FETCH;
  assign imem_addr = r_pc;
  assign alu_op = r_alu_op;
  assign alu_a = r_alu_a;
  assign alu_b = r_alu_b;
  assign busy = !w_idle;
  assign done = r_done;
  assign zero_flag = r_zero;
  assign retired = r_retired;
  assign dbg_data = dbg_addr == 4'd0 ? 8'h00 : r_rf[dbg_addr];
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALTED: w_next = w_start ? S_FETCH : abort ? S_IDLE : r_state;
      S_FETCH:          w_next = S_DECODE;
      S_DECODE:         w_next = w_op == OP_HALT ? S_HALTED : w_op == OP_LDI ? S_WB : S_EXEC;
      S_EXEC:           w_next = S_WB;
      S_WB:             w_next = S_FETCH;
      default:          w_next = S_IDLE;
    endcase
    if (abort && !w_idle) w_next = S_IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_pc <= IMEM_AW'(PROG_START);
      r_ir <= '0;
      r_retired <= '0;
      r_res <= '0;
      r_res_zero <= 1'b0;
      r_alu_op <= '0;
      r_alu_a <= '0;
      r_alu_b <= '0;
      r_zero <= 1'b0;
      r_done <= 1'b0;
      for (int i = 0; i < 16; i++) r_rf[i] <= '0;
    end else begin
      r_state <= w_next;
      r_done <= r_state == S_DECODE && w_op == OP_HALT && !abort;
      if (w_start) begin
        r_pc <= IMEM_AW'(PROG_START);
        r_retired <= '0;
        r_zero <= 1'b0;
      end
      // An abort cancels every side effect of the cycle it is sampled in.
      if (!abort && r_state == S_DECODE) begin
        r_ir <= imem_rdata;
        if (w_op < OP_LDI) begin
          r_alu_op <= w_op;
          r_alu_a <= r_rf[imem_rdata[7:4]];
          r_alu_b <= r_rf[imem_rdata[3:0]];
        end
      end
      if (!abort && r_state == S_EXEC) begin
        r_res <= alu_result;
        r_res_zero <= alu_zero;
      end
      if (!abort && r_state == S_WB) begin
        if (r_ir[11:8] != 4'd0) r_rf[r_ir[11:8]] <= w_ldi ? r_ir[7:0] : r_res;
        r_pc <= r_pc + IMEM_AW'(1);
        r_retired <= r_retired + {15'd0, ~&r_retired};
        if (!w_ldi) r_zero <= r_res_zero;
      end
    end
  end
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: randomized programs scored against an instruction-level reference model;
// a monitor pops the expected outcome whenever busy falls (halt, abort or reset).
module tb_instr_sequencer;
  localparam int PS = 255;
  localparam logic [15:0] HALT = 16'hE000;
  typedef struct packed {
    logic         done;
    logic         rst;
    logic [31:0]  cyc;
    logic [15:0]  ret;
    logic         z;
    logic [127:0] regs;
  } exp_t;

  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic imem_rd_en;
  logic [7:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0;
  logic [2:0] alu_op;
  logic [7:0] alu_a, alu_b, alu_result;
  logic alu_zero, busy, done, zero_flag;
  logic [15:0] retired;
  logic [3:0] dbg_addr = 4'd0;
  logic [7:0] dbg_data;

  logic [15:0] imem [256];
  logic [7:0] m_regs [16];
  logic [15:0] prog [$];
  exp_t q [$];
  int cyc = 0, n_chk = 0, n_fail = 0;
  logic mon_act = 1'b0, pb = 1'b0;

  instr_sequencer #(.PROG_START(PS), .IMEM_AW(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .busy(busy), .done(done), .zero_flag(zero_flag), .retired(retired),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (imem_rd_en) imem_rdata <= imem[imem_addr];

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  always_comb alu_result = alu_f(alu_op, alu_a, alu_b);
  assign alu_zero = alu_result == 8'h00;

  function automatic logic [15:0] ldi(input logic [3:0] rd, input logic [7:0] imm);
    return {3'b110, 1'b0, rd, imm};
  endfunction

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [3:0] rd, input logic [3:0] a, input logic [3:0] b);
    return {op, 1'b0, rd, a, b};
  endfunction

  function automatic int plen();
    int t = 0;
    foreach (prog[i]) t += prog[i][15:13] == 3'b111 ? 2 : prog[i][15:13] == 3'b110 ? 3 : 4;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  // Executes the loaded program instruction by instruction; an abort sampled at edge ea
  // (counted from the start-sampling edge) cancels any instruction not yet committed.
  task automatic model(input int ea, output exp_t e);
    int pc = PS, t = 0, lat;
    logic [15:0] ins;
    logic [7:0] res;
    e = '0;
    for (int n = 0; n < 300; n++) begin
      ins = imem[pc];
      if (ins[15:13] == 3'b111) begin
        if (t + 2 < ea) begin
          e.done = 1'b1;
          t += 2;
        end
        break;
      end
      lat = ins[15:13] == 3'b110 ? 3 : 4;
      if (t + lat >= ea) break;
      t += lat;
      res = ins[15:13] == 3'b110 ? ins[7:0] : alu_f(ins[15:13], m_regs[ins[7:4]], m_regs[ins[3:0]]);
      if (ins[11:8] != 4'd0) m_regs[ins[11:8]] = res;
      if (ins[15:13] != 3'b110) e.z = res == 8'h00;
      e.ret = e.ret + 16'd1;
      pc = (pc + 1) % 256;
    end
    e.cyc = e.done ? 32'(t) : 32'(ea);
    for (int i = 0; i < 16; i++) e.regs[i*8 +: 8] = m_regs[i];
  endtask

  task automatic wait_mon();
    int n = 0;
    while ((q.size() != 0 || mon_act) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_timeout actual=pending:%0d required=0", q.size());
      q.delete();
    end
  endtask

  task automatic place();
    foreach (prog[i]) imem[(PS + i) % 256] = prog[i];
  endtask

  task automatic run(input int ea);
    exp_t e;
    int k;
    place();
    @(negedge clk);
    model(ea > 0 ? ea : 1 << 30, e);
    k = cyc;
    e.cyc = e.cyc + 32'(k + 1);
    q.push_back(e);
    start = 1'b1;
    @(negedge clk);
    if (ea == 0) @(negedge clk);
    start = 1'b0;
    if (ea > 0) begin
      while (cyc < k + ea) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    wait_mon();
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pb && !busy) begin
        mon_act = 1'b1;
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_stop actual=busy_fell required=no_event");
        end else begin
          e = q.pop_front();
          chk("done", 32'(done), 32'(e.done));
          if (!e.rst) chk("event_cycle", 32'(cyc), e.cyc);
          chk("retired", 32'(retired), 32'(e.ret));
          chk("zero_flag", 32'(zero_flag), 32'(e.z));
          if (e.rst) begin
            chk("rst_rd_en", 32'(imem_rd_en), 0);
            chk("rst_alu", 32'({alu_op, alu_a, alu_b}), 0);
            chk("rst_addr", 32'(imem_addr), PS);
          end
          @(negedge clk);
          chk("done_one_cycle", 32'(done), 0);
          for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            chk($sformatf("reg_r%0d", i), 32'(dbg_data), 32'(e.regs[i*8 +: 8]));
          end
        end
        mon_act = 1'b0;
      end
      pb = busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int k, n;
    logic [2:0] op;
    for (int i = 0; i < 256; i++) imem[i] = HALT;
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    prog = {ldi(4'd7, 8'h5A), HALT};
    run(0);
    prog = {ldi(4'd1, 8'h05), ldi(4'd2, 8'h03), alu(3'd1, 4'd3, 4'd1, 4'd2), HALT};
    run(0);
    prog = {ldi(4'd1, 8'hFF), ldi(4'd2, 8'h01), alu(3'd0, 4'd4, 4'd1, 4'd2), ldi(4'd5, 8'h00), HALT};
    run(0);
    prog = {ldi(4'd0, 8'hAA), alu(3'd3, 4'd6, 4'd0, 4'd0), HALT};
    run(0);
    prog = {ldi(4'd1, 8'h21), ldi(4'd2, 8'h13), alu(3'd0, 4'd7, 4'd1, 4'd2), HALT};
    run(9);
    prog = {ldi(4'd1, 8'h11), HALT};
    run(0);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("abort_beats_start", 32'(busy), 0);
    for (int r = 0; r < 25; r++) begin
      prog = {};
      n = $urandom_range(8, 1);
      for (int i = 0; i < n; i++) begin
        op = 3'($urandom_range(6, 0));
        prog.push_back({op, 1'($urandom), 4'($urandom), 8'($urandom)});
      end
      prog.push_back(HALT);
      if ($urandom_range(3, 0) == 0) run(int'($urandom_range(plen() - 1, 1)));
      else run(0);
    end
    prog = {ldi(4'd1, 8'h05), ldi(4'd2, 8'h03), alu(3'd1, 4'd3, 4'd1, 4'd2), HALT};
    place();
    @(negedge clk);
    k = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (cyc < k + 8) @(negedge clk);
    @(posedge clk);
    #2;
    e = '0;
    e.rst = 1'b1;
    q.push_back(e);
    reset_n = 1'b0;
    wait_mon();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    prog = {ldi(4'd9, 8'h3C), alu(3'd4, 4'd10, 4'd9, 4'd9), HALT};
    run(0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
